seq_normalizer16: RTL and testbench

SEQ_NORMALIZER16 -- requirements
Module: seq_normalizer16

---
 rtl/seq_normalizer16.sv | 164 ++++++++++++++++
 tb/tb_seq_normalizer16.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_normalizer16.sv
// -----------------------------------------------------------------------------
// seq_normalizer16
//
// Purpose:
//   Sequential 16-bit normalizer. It finds the leading-zero count of a word
//   and left-shifts the word by that count, zero-filled, so that bit 15 of the
//   result is set unless the input was zero. The shift is done iteratively,
//   one step per clock, in a three-state FSM (IDLE / SHIFT / DONE).
//
//   Inputs that need no shifting (0x0000, or bit 15 already set) go straight
//   to DONE on the accept edge. Everything else enters SHIFT, and the result
//   loads on the edge where the shifted word first has bit 15 set.
//
// Optional feature (compile-time macro NORM_SKIP4_EN):
//   When defined, a SHIFT step moves 4 places at once whenever the top nibble
//   of the work register is zero, and 1 place otherwise. The results are
//   identical to the default build; only the number of SHIFT cycles changes.
//   When undefined (the default), every step moves exactly 1 place.
//
// Handshakes:
//   Both ports use valid/ready. A transfer happens on a rising edge where
//   valid and ready are both high. The producer keeps valid and data stable
//   until that edge; ready may change freely and never depends on valid in
//   the same cycle.
//   - Input:  in_valid/in_ready. in_ready is high only in IDLE; in_valid
//             outside IDLE is ignored.
//   - Output: out_valid/out_ready. out_valid is high only in DONE; the
//             result stays stable until the transfer edge.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   in_valid   in   1   in_data is valid this cycle
//   in_ready   out  1   block can accept a word (high only in IDLE)
//   in_data    in  16   word to normalize
//   out_valid  out  1   result is valid (registered)
//   out_ready  in   1   consumer accepts the result
//   out_data   out 16   normalized word (registered)
//   out_shamt  out  4   left-shift count applied, 0..15 (registered)
//   out_zero   out  1   input word was 0x0000 (registered)
//   dbg_state  out  2   current FSM state: 0=IDLE, 1=SHIFT, 2=DONE
// -----------------------------------------------------------------------------
module seq_normalizer16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_shamt,
  output logic        out_zero,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] work_q;
  logic [3:0]  count_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic [3:0]  out_shamt_q;
  logic        out_zero_q;

  // Result of one SHIFT step, computed from the current work/count.
  logic [15:0] work_d;
  logic [3:0]  count_d;

  logic accept;
  logic release_result;

  assign in_ready       = (state_q == ST_IDLE);
  assign accept         = in_valid & in_ready;
  assign release_result = out_valid_q & out_ready;

  always_comb begin
    work_d  = {work_q[14:0], 1'b0};
    count_d = count_q + 4'd1;
`ifdef NORM_SKIP4_EN
    // A zero top nibble guarantees at least four leading zeros, so a 4-place
    // step can never shift past the leading one.
    if (work_q[15:12] == 4'd0) begin
      work_d  = {work_q[11:0], 4'b0000};
      count_d = count_q + 4'd4;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      work_q      <= 16'h0000;
      count_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_shamt_q <= 4'd0;
      out_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            work_q  <= in_data;
            count_q <= 4'd0;
            if (in_data == 16'h0000) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= 16'h0000;
              out_shamt_q <= 4'd0;
              out_zero_q  <= 1'b1;
            end else if (in_data[15]) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              out_shamt_q <= 4'd0;
              out_zero_q  <= 1'b0;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          work_q  <= work_d;
          count_q <= count_d;
          // Exit on the step that brings the leading one into bit 15; the
          // result registers load on that same edge.
          if (work_d[15]) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= work_d;
            out_shamt_q <= count_d;
            out_zero_q  <= 1'b0;
          end
        end

        ST_DONE: begin
          if (release_result) begin
            // Result registers keep their value until the next load.
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_shamt = out_shamt_q;
  assign out_zero  = out_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_normalizer16.sv
// -----------------------------------------------------------------------------
// tb_seq_normalizer16
//
// Directed bench for seq_normalizer16. Inputs are driven on the falling edge,
// outputs are sampled 1 ns after the rising edge. Latency is counted in rising
// edges after the accept edge; a pass-through word (zero or bit 15 set) shows
// its result right after the accept edge itself.
// -----------------------------------------------------------------------------
module tb_seq_normalizer16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_shamt;
  logic        out_zero;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  seq_normalizer16 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [15:0] d);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 16'hffff);
  endtask

  // Wait for out_valid after an accept and check latency and result.
  task automatic expect_result(input string tag, input int exp_n,
                               input logic [15:0] exp_data, input logic [3:0] exp_shamt,
                               input logic exp_zero);
    int edges;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, edges, exp_n);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_shamt"}, out_shamt, exp_shamt);
    chk({tag, "_zero"}, out_zero, exp_zero);
    chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
  endtask

  // Complete the output handshake and check the block is idle again.
  task automatic drain(input string tag, input logic [15:0] exp_data);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_in_ready_back"}, in_ready, 1'b1);
    chk({tag, "_data_held"}, out_data, exp_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_a5, n_1, n_400, n_1234, n_f00;
    logic saw_valid;

`ifdef NORM_SKIP4_EN
    n_a5 = 2; n_1 = 6; n_400 = 2; n_1234 = 3; n_f00 = 1;
`else
    n_a5 = 8; n_1 = 15; n_400 = 5; n_1234 = 3; n_f00 = 4;
`endif

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;

    // Reset state, with in_valid pulsed to show no accept happens in reset.
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_shamt", out_shamt, 4'd0);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_state", dbg_state, 2'd0);
    in_valid = 1'b1;
    in_data  = 16'h8000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_accept_state", dbg_state, 2'd0);
    chk("rst_no_accept_valid", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;

    // Pass-through word.
    send(16'h8000);
    expect_result("w8000", 0, 16'h8000, 4'd0, 1'b0);
    drain("w8000", 16'h8000);

    send(16'h00A5);
    expect_result("w00a5", n_a5, 16'hA500, 4'd8, 1'b0);
    drain("w00a5", 16'hA500);

    // Worst case: 15 leading zeros.
    send(16'h0001);
    expect_result("w0001", n_1, 16'h8000, 4'd15, 1'b0);
    drain("w0001", 16'h8000);

    // Zero word.
    send(16'h0000);
    expect_result("w0000", 0, 16'h0000, 4'd0, 1'b1);
    drain("w0000", 16'h0000);

    send(16'h1234);
    expect_result("w1234", n_1234, 16'h91A0, 4'd3, 1'b0);
    drain("w1234", 16'h91A0);

    send(16'h0F00);
    expect_result("w0f00", n_f00, 16'hF000, 4'd4, 1'b0);
    drain("w0f00", 16'hF000);

    // Back-pressure: result held stable, new input ignored while busy.
    send(16'h0400);
    expect_result("w0400", n_400, 16'h8000, 4'd5, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0003;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 16'h8000);
      chk("stall_shamt", out_shamt, 4'd5);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    drain("w0400", 16'h8000);
    chk("w0400_shamt_held", out_shamt, 4'd5);

    // Reset in the middle of a SHIFT sequence.
    send(16'h0001);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 16'h0000);
    chk("midrst_shamt", out_shamt, 4'd0);
    chk("midrst_zero", out_zero, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_valid_pulse", saw_valid, 1'b0);

    send(16'hAA55);
    expect_result("waa55", 0, 16'hAA55, 4'd0, 1'b0);
    drain("waa55", 16'hAA55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of stimulus, expected end before 200000");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
